// File: rtl/quadrature_pkg.sv
// Shared types and phase-sequence helper for the quadrature decoder.
// The forward order is 00 -> 01 -> 11 -> 10 -> 00.
package quadrature_pkg;

    typedef logic [1:0] quad_phase_t;

    localparam quad_phase_t PH_00 = 2'b00;
    localparam quad_phase_t PH_01 = 2'b01;
    localparam quad_phase_t PH_11 = 2'b11;
    localparam quad_phase_t PH_10 = 2'b10;

    function automatic quad_phase_t next_fwd(input quad_phase_t p);
        quad_phase_t n;
        case (p)
            PH_00:   n = PH_01;
            PH_01:   n = PH_11;
            PH_11:   n = PH_10;
            default: n = PH_00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Quadrature inputs and decoded step/error outputs.
// master = decoder side, slave = the consumer and stimulus side.
interface quadrature_decoder_if;
    import quadrature_pkg::*;

    logic        a_i;
    logic        b_i;
    logic        up_o;
    logic        down_o;
    logic        error_o;
    logic        error_sticky_o;
    quad_phase_t phase_o;

    modport master (
        input  a_i,
        input  b_i,
        output up_o,
        output down_o,
        output error_o,
        output error_sticky_o,
        output phase_o
    );

    modport slave (
        output a_i,
        output b_i,
        input  up_o,
        input  down_o,
        input  error_o,
        input  error_sticky_o,
        input  phase_o
    );

endinterface

// File: rtl/quad_channel_filter.sv
// One quadrature channel: synchronizer chain followed by a glitch filter that only
// accepts a new level after it has held for filter_cycles_p synced cycles.
module quad_channel_filter #(
    parameter int unsigned sync_stages_p   = 2,
    parameter int unsigned filter_cycles_p = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic filt_o
);

    localparam int unsigned CntW = (filter_cycles_p > 1) ? $clog2(filter_cycles_p) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(filter_cycles_p - 1);

    logic [sync_stages_p-1:0] sync_q;
    logic                     synced;
    logic                     filt_q, filt_d;
    logic [CntW-1:0]          cnt_q, cnt_d;

    // Synchronizer is deliberately unreset so it keeps flushing during reset.
    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[sync_stages_p-2:0], raw_i};
    end

    assign synced = sync_q[sync_stages_p-1];

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (synced == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            filt_d = synced;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filt_q <= synced;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filters both channels, tracks the Gray-code phase and emits
// registered one-cycle up/down/error pulses plus a sticky error flag.
module quadrature_decoder
    import quadrature_pkg::*;
#(
    parameter int unsigned sync_stages_p   = 2,
    parameter int unsigned filter_cycles_p = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    quadrature_decoder_if.master bus
);

    logic        a_f, b_f;
    quad_phase_t phase_cur, phase_q;
    logic        up_d, down_d, err_d;
    logic        up_q, down_q, err_q, sticky_q;

    quad_channel_filter #(
        .sync_stages_p  (sync_stages_p),
        .filter_cycles_p(filter_cycles_p)
    ) u_filt_a (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .raw_i  (bus.a_i),
        .filt_o (a_f)
    );

    quad_channel_filter #(
        .sync_stages_p  (sync_stages_p),
        .filter_cycles_p(filter_cycles_p)
    ) u_filt_b (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .raw_i  (bus.b_i),
        .filt_o (b_f)
    );

    assign phase_cur = {a_f, b_f};

    always_comb begin
        up_d   = 1'b0;
        down_d = 1'b0;
        err_d  = 1'b0;
        if (phase_cur != phase_q) begin
            if (next_fwd(phase_q) == phase_cur) begin
                up_d = 1'b1;
            end else if (next_fwd(phase_cur) == phase_q) begin
                down_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // phase_q follows the filtered phase even in reset so release sees no stale step.
    always_ff @(posedge clk_i) begin
        phase_q <= phase_cur;
        if (reset_i) begin
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            up_q     <= up_d;
            down_q   <= down_d;
            err_q    <= err_d;
            sticky_q <= sticky_q | err_d;
        end
    end

    assign bus.up_o           = up_q;
    assign bus.down_o         = down_q;
    assign bus.error_o        = err_q;
    assign bus.error_sticky_o = sticky_q;
    assign bus.phase_o        = phase_cur;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: a cycle model predicts every output,
// directed scenarios plus a random phase walk exercise steps, glitches, jumps and resets.
module tb_quadrature_decoder;
    import quadrature_pkg::*;

    localparam int SS = 2;
    localparam int FC = 3;

    typedef struct packed {
        logic        chk;
        logic        up;
        logic        down;
        logic        err;
        logic        sticky;
        logic [1:0]  phase;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    quadrature_decoder_if bus();

    quadrature_decoder #(
        .sync_stages_p  (SS),
        .filter_cycles_p(FC)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    exp_t exp_q[$];
    int   up_seen = 0, down_seen = 0, err_seen = 0;
    logic [3:0] cnt4 = 4'd0;

    // ---------------- reference model ----------------
    bit          hist_a[$], hist_b[$];
    bit          sa_hist[$], sb_hist[$];
    bit          fa = 1'b0, fb = 1'b0, m_sticky = 1'b0;
    quad_phase_t p1 = PH_00, p2 = PH_00;
    int          valid_edges = 0;

    // A new level is accepted once the last FC synced samples all disagree with it.
    function automatic bit all_differ(input bit h[$], input bit f);
        if (h.size() < FC) return 1'b0;
        for (int i = 0; i < FC; i++) begin
            if (h[h.size() - 1 - i] == f) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        exp_t e;
        bit   sa, sb, up_e, dn_e, er_e;
        e = '0;
        hist_a.push_back(bus.a_i);
        hist_b.push_back(bus.b_i);
        if (hist_a.size() > SS + 1) begin
            void'(hist_a.pop_front());
            void'(hist_b.pop_front());
        end
        if (hist_a.size() == SS + 1) begin
            sa = hist_a[0];
            sb = hist_b[0];
            sa_hist.push_back(sa);
            sb_hist.push_back(sb);
            if (sa_hist.size() > FC) begin
                void'(sa_hist.pop_front());
                void'(sb_hist.pop_front());
            end
            if (rst) begin
                fa = sa;
                fb = sb;
            end else begin
                if (all_differ(sa_hist, fa)) fa = sa;
                if (all_differ(sb_hist, fb)) fb = sb;
            end
            up_e = !rst && (p1 != p2) && (next_fwd(p2) == p1);
            dn_e = !rst && (p1 != p2) && (next_fwd(p1) == p2);
            er_e = !rst && ((p1 ^ p2) == 2'b11);
            m_sticky = rst ? 1'b0 : (m_sticky | er_e);
            p2 = p1;
            p1 = {fa, fb};
            valid_edges++;
            e.chk    = (valid_edges >= 3);
            e.up     = up_e;
            e.down   = dn_e;
            e.err    = er_e;
            e.sticky = m_sticky;
            e.phase  = p1;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.up_o === 1'b1) begin up_seen++; cnt4 = cnt4 + 4'd1; end
            if (bus.down_o === 1'b1) begin down_seen++; cnt4 = cnt4 - 4'd1; end
            if (bus.error_o === 1'b1) err_seen++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard_empty t=%0t no expectation queued", $time);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    compared++;
                    if (bus.up_o !== e.up || bus.down_o !== e.down || bus.error_o !== e.err ||
                        bus.error_sticky_o !== e.sticky || bus.phase_o !== e.phase) begin
                        mismatched++;
                        $display("FAIL cycle_check t=%0t got up=%b dn=%b err=%b stk=%b ph=%b exp up=%b dn=%b err=%b stk=%b ph=%b",
                                 $time, bus.up_o, bus.down_o, bus.error_o, bus.error_sticky_o,
                                 bus.phase_o, e.up, e.down, e.err, e.sticky, e.phase);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check(input string name, input int got, input int expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic drive(input quad_phase_t p, input int n);
        bus.a_i = p[1];
        bus.b_i = p[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic quad_phase_t prev_ph(input quad_phase_t p);
        return next_fwd(next_fwd(next_fwd(p)));
    endfunction

    initial begin
        int u0, d0, e0;
        logic [3:0] c0;
        quad_phase_t cur;
        quad_phase_t fwd_seq[4];
        quad_phase_t rev_seq[4];
        fwd_seq = '{PH_01, PH_11, PH_10, PH_00};
        rev_seq = '{PH_10, PH_11, PH_01, PH_00};

        bus.a_i = 1'b1;
        bus.b_i = 1'b1;
        @(negedge clk);
        do_reset(10);
        check("reset_phase", int'(bus.phase_o), 3);
        u0 = up_seen; d0 = down_seen; e0 = err_seen;
        repeat (20) @(negedge clk);
        check("reset_quiet_up", up_seen - u0, 0);
        check("reset_quiet_down", down_seen - d0, 0);
        check("reset_quiet_err", err_seen - e0, 0);

        drive(PH_10, 8);
        drive(PH_00, 8);
        u0 = up_seen; d0 = down_seen;
        for (int i = 0; i < 4; i++) drive(fwd_seq[i], 8);
        check("fwd_up_count", up_seen - u0, 4);
        check("fwd_down_count", down_seen - d0, 0);

        u0 = up_seen; d0 = down_seen;
        for (int i = 0; i < 4; i++) drive(rev_seq[i], 8);
        check("rev_down_count", down_seen - d0, 4);
        check("rev_up_count", up_seen - u0, 0);
        check("rev_phase_end", int'(bus.phase_o), 0);

        u0 = up_seen;
        drive(PH_10, 2);
        drive(PH_00, 12);
        check("glitch2_up", up_seen - u0, 0);
        check("glitch2_phase", int'(bus.phase_o), 0);
        u0 = up_seen;
        drive(PH_10, 3);
        drive(PH_00, 12);
        check("glitch3_up", up_seen - u0, 1);

        u0 = up_seen; d0 = down_seen; e0 = err_seen;
        drive(PH_11, 10);
        check("jump_err", err_seen - e0, 1);
        check("jump_up", up_seen - u0, 0);
        check("jump_down", down_seen - d0, 0);
        check("jump_phase", int'(bus.phase_o), 3);
        drive(PH_11, 20);
        check("sticky_held", int'(bus.error_sticky_o), 1);
        do_reset(3);
        check("sticky_cleared", int'(bus.error_sticky_o), 0);

        u0 = up_seen; d0 = down_seen;
        drive(PH_01, 2);
        do_reset(4);
        drive(PH_01, 10);
        check("midreset_down", down_seen - d0, 0);
        check("midreset_up", up_seen - u0, 0);
        check("midreset_phase", int'(bus.phase_o), 1);
        u0 = up_seen;
        drive(PH_11, 8);
        check("after_release_up", up_seen - u0, 1);

        drive(PH_10, 8);
        drive(PH_00, 8);
        c0 = cnt4;
        cur = PH_00;
        for (int i = 0; i < 20; i++) begin
            cur = next_fwd(cur);
            drive(cur, 8);
        end
        check("count_fwd20", int'(cnt4 - c0), 4);
        for (int i = 0; i < 20; i++) begin
            cur = prev_ph(cur);
            drive(cur, 8);
        end
        check("count_rev20", int'(cnt4 - c0), 0);

        // Random walk: legal steps, holds, illegal jumps, glitches and short resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 35) cur = next_fwd(cur);
            else if (r < 70) cur = prev_ph(cur);
            else if (r < 80) cur = cur ^ 2'b11;
            else if (r < 85) begin
                drive(cur ^ 2'b10, $urandom_range(1, 3));
            end else if (r < 90) begin
                rst = 1'b1;
            end
            drive(cur, $urandom_range(1, 10));
            rst = 1'b0;
        end
        drive(cur, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
